// File: rtl/cpu_decode_pkg.sv
// Shared definitions for the instruction decode stage: opcode class bounds,
// ALU operation codes and the RUN/HALT state type.
package cpu_decode_pkg;

    // Opcode class bounds (opcode is instr[31:26])
    localparam logic [5:0] OP_HALT = 6'd0;
    localparam logic [5:0] R_LO    = 6'd1;
    localparam logic [5:0] R_HI    = 6'd15;
    localparam logic [5:0] I_LO    = 6'd16;
    localparam logic [5:0] I_HI    = 6'd23;
    localparam logic [5:0] M_LO    = 6'd24;
    localparam logic [5:0] M_HI    = 6'd27;
    localparam logic [5:0] BR_EQ   = 6'd62;
    localparam logic [5:0] BR_NE   = 6'd63;

    // ALU operation codes. R-type instructions use {0, op[3:0]} directly,
    // so the low codes line up with the R-type opcode numbering.
    localparam logic [4:0] ALU_NONE  = 5'b00000;
    localparam logic [4:0] ALU_ADD   = 5'b00001;
    localparam logic [4:0] ALU_I3    = 5'b00010;
    localparam logic [4:0] ALU_I4    = 5'b00011;
    localparam logic [4:0] ALU_I5    = 5'b00100;
    localparam logic [4:0] ALU_I6    = 5'b01001;
    localparam logic [4:0] ALU_I7    = 5'b01010;
    localparam logic [4:0] ALU_BR_NE = 5'b01111;
    localparam logic [4:0] ALU_BR_EQ = 5'b10000;

    // Stage run state: RUN lets fetch advance, HALT freezes the PC
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    // Inclusive opcode range test used to classify instructions
    function automatic logic in_range(input logic [5:0] op,
                                      input logic [5:0] lo,
                                      input logic [5:0] hi);
        return (op >= lo) && (op <= hi);
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Pure combinational decoder: one 32-bit instruction word in, one decoded
// control/operand bundle out. Fields a class does not use are driven to 0.
// RA_W must not exceed 5 because register fields are fixed 5-bit slots.
module decode_comb
    import cpu_decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic [31:0]     instr,
    output logic [RA_W-1:0] rd,
    output logic [RA_W-1:0] rs1,
    output logic [RA_W-1:0] rs2,
    output logic [4:0]      shamt,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      alu_op,
    output logic            alu_src_imm,
    output logic            wb_from_alu,
    output logic            reg_we,
    output logic            mem_we,
    output logic            jump,
    output logic            illegal,
    output logic            is_halt
);

    logic [5:0]      op;
    logic [4:0]      field_a;
    logic [4:0]      field_b;
    logic [4:0]      field_c;
    logic [XLEN-1:0] imm_sext;

    assign op       = instr[31:26];
    assign field_a  = instr[25:21];
    assign field_b  = instr[20:16];
    assign field_c  = instr[15:11];
    assign imm_sext = {{(XLEN-16){instr[15]}}, instr[15:0]};

    // Classify the opcode and fill only the fields that class defines
    always_comb begin
        rd          = '0;
        rs1         = '0;
        rs2         = '0;
        shamt       = '0;
        imm         = '0;
        alu_op      = ALU_NONE;
        alu_src_imm = 1'b0;
        wb_from_alu = 1'b0;
        reg_we      = 1'b0;
        mem_we      = 1'b0;
        jump        = 1'b0;
        illegal     = 1'b0;
        is_halt     = 1'b0;

        if (op == OP_HALT) begin
            is_halt = 1'b1;
        end else if (in_range(op, R_LO, R_HI)) begin
            rd          = field_a[RA_W-1:0];
            rs1         = field_b[RA_W-1:0];
            rs2         = field_c[RA_W-1:0];
            shamt       = instr[10:6];
            alu_op      = {1'b0, op[3:0]};
            wb_from_alu = 1'b1;
            reg_we      = 1'b1;
        end else if (in_range(op, I_LO, I_HI)) begin
            rd          = field_a[RA_W-1:0];
            rs1         = field_b[RA_W-1:0];
            imm         = imm_sext;
            alu_src_imm = 1'b1;
            wb_from_alu = 1'b1;
            reg_we      = 1'b1;
            case (op[3:0])
                4'd2:    alu_op = ALU_ADD;
                4'd3:    alu_op = ALU_I3;
                4'd4:    alu_op = ALU_I4;
                4'd5:    alu_op = ALU_I5;
                4'd6:    alu_op = ALU_I6;
                4'd7:    alu_op = ALU_I7;
                default: alu_op = ALU_NONE;
            endcase
        end else if (in_range(op, M_LO, M_HI)) begin
            // Address is always base + offset; op[0] separates stores from loads
            alu_op      = ALU_ADD;
            alu_src_imm = 1'b1;
            imm         = imm_sext;
            mem_we      = op[0];
            if (op[0]) begin
                rs1 = field_a[RA_W-1:0];
                rs2 = field_b[RA_W-1:0];
            end else begin
                rd     = field_a[RA_W-1:0];
                rs1    = field_b[RA_W-1:0];
                reg_we = 1'b1;
            end
        end else if ((op == BR_EQ) || (op == BR_NE)) begin
            rs1    = field_a[RA_W-1:0];
            rs2    = field_b[RA_W-1:0];
            imm    = imm_sext;
            jump   = 1'b1;
            alu_op = (op == BR_EQ) ? ALU_BR_EQ : ALU_BR_NE;
        end else begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between fetch and register-read. Wraps the
// combinational decoder with a valid/ready output register, a RUN/HALT
// state machine driven by the halt opcode, flush and a saturating counter
// of emitted bundles.
module decode_stage
    import cpu_decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic             flush,
    input  logic             resume,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RA_W-1:0]  rd,
    output logic [RA_W-1:0]  rs1,
    output logic [RA_W-1:0]  rs2,
    output logic [4:0]       shamt,
    output logic [XLEN-1:0]  imm,
    output logic [4:0]       alu_op,
    output logic             alu_src_imm,
    output logic             wb_from_alu,
    output logic             reg_we,
    output logic             mem_we,
    output logic             jump,
    output logic             illegal,
    output logic             pc_enable,
    output logic             halted,
    output logic [CNT_W-1:0] decode_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e          state;
    logic            accept;
    logic            load;

    logic [RA_W-1:0] dec_rd;
    logic [RA_W-1:0] dec_rs1;
    logic [RA_W-1:0] dec_rs2;
    logic [4:0]      dec_shamt;
    logic [XLEN-1:0] dec_imm;
    logic [4:0]      dec_alu_op;
    logic            dec_alu_src_imm;
    logic            dec_wb_from_alu;
    logic            dec_reg_we;
    logic            dec_mem_we;
    logic            dec_jump;
    logic            dec_illegal;
    logic            dec_is_halt;

    decode_comb #(
        .XLEN (XLEN),
        .RA_W (RA_W)
    ) u_decode (
        .instr       (instr),
        .rd          (dec_rd),
        .rs1         (dec_rs1),
        .rs2         (dec_rs2),
        .shamt       (dec_shamt),
        .imm         (dec_imm),
        .alu_op      (dec_alu_op),
        .alu_src_imm (dec_alu_src_imm),
        .wb_from_alu (dec_wb_from_alu),
        .reg_we      (dec_reg_we),
        .mem_we      (dec_mem_we),
        .jump        (dec_jump),
        .illegal     (dec_illegal),
        .is_halt     (dec_is_halt)
    );

    // Accept only while running, with room in the output register, and never
    // during a flush so a same-cycle input is dropped at the handshake.
    assign in_ready = (state == ST_RUN) && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign load     = accept && !dec_is_halt;

    // Output register: flush empties it, a load refills it, a consume drains it
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid   <= 1'b0;
            rd          <= '0;
            rs1         <= '0;
            rs2         <= '0;
            shamt       <= '0;
            imm         <= '0;
            alu_op      <= ALU_NONE;
            alu_src_imm <= 1'b0;
            wb_from_alu <= 1'b0;
            reg_we      <= 1'b0;
            mem_we      <= 1'b0;
            jump        <= 1'b0;
            illegal     <= 1'b0;
        end else if (load) begin
            out_valid   <= 1'b1;
            rd          <= dec_rd;
            rs1         <= dec_rs1;
            rs2         <= dec_rs2;
            shamt       <= dec_shamt;
            imm         <= dec_imm;
            alu_op      <= dec_alu_op;
            alu_src_imm <= dec_alu_src_imm;
            wb_from_alu <= dec_wb_from_alu;
            reg_we      <= dec_reg_we;
            mem_we      <= dec_mem_we;
            jump        <= dec_jump;
            illegal     <= dec_illegal;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // RUN/HALT machine; the halt opcode is swallowed here and never emitted
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            pc_enable <= 1'b1;
            halted    <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (accept && dec_is_halt) begin
                        state     <= ST_HALT;
                        pc_enable <= 1'b0;
                        halted    <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (resume) begin
                        state     <= ST_RUN;
                        pc_enable <= 1'b1;
                        halted    <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_RUN;
                    pc_enable <= 1'b1;
                    halted    <= 1'b0;
                end
            endcase
        end
    end

    // Count every bundle loaded into the output register, sticking at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            decode_count <= '0;
        end else if (load && (decode_count != CNT_MAX)) begin
            decode_count <= decode_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a behavioural model of the stage is
// compared against the DUT every cycle, plus directed literal expectations.
// A second instance with a 2-bit counter shares the stimulus to show saturation.
module tb_decode_stage;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  shamt;
        logic [31:0] imm;
        logic [4:0]  alu_op;
        logic        alu_src_imm;
        logic        wb_from_alu;
        logic        reg_we;
        logic        mem_we;
        logic        jump;
        logic        illegal;
    } bundle_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] instr;
    logic        flush;
    logic        resume;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [4:0]  rd, rs1, rs2, shamt, alu_op;
    logic [31:0] imm;
    logic        alu_src_imm, wb_from_alu, reg_we, mem_we, jump, illegal;
    logic        pc_enable, halted;
    logic [15:0] decode_count;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [4:0]  s_rd, s_rs1, s_rs2, s_shamt, s_alu_op;
    logic [31:0] s_imm;
    logic        s_alu_src_imm, s_wb_from_alu, s_reg_we, s_mem_we, s_jump, s_illegal;
    logic        s_pc_enable, s_halted;
    logic [1:0]  s_decode_count;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Model state
    logic    m_init  = 1'b0;
    logic    m_valid = 1'b0;
    logic    m_halt  = 1'b0;
    int      m_count = 0;
    bundle_t m_b     = '0;

    decode_stage #(.XLEN(32), .RA_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .flush(flush), .resume(resume),
        .out_valid(out_valid), .out_ready(out_ready),
        .rd(rd), .rs1(rs1), .rs2(rs2), .shamt(shamt), .imm(imm),
        .alu_op(alu_op), .alu_src_imm(alu_src_imm), .wb_from_alu(wb_from_alu),
        .reg_we(reg_we), .mem_we(mem_we), .jump(jump), .illegal(illegal),
        .pc_enable(pc_enable), .halted(halted), .decode_count(decode_count)
    );

    decode_stage #(.XLEN(32), .RA_W(5), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .instr(instr), .flush(flush), .resume(resume),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .rd(s_rd), .rs1(s_rs1), .rs2(s_rs2), .shamt(s_shamt), .imm(s_imm),
        .alu_op(s_alu_op), .alu_src_imm(s_alu_src_imm), .wb_from_alu(s_wb_from_alu),
        .reg_we(s_reg_we), .mem_we(s_mem_we), .jump(s_jump), .illegal(s_illegal),
        .pc_enable(s_pc_enable), .halted(s_halted), .decode_count(s_decode_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode written straight from the opcode table
    function automatic bundle_t model_decode(input logic [31:0] w);
        bundle_t     b;
        int          op;
        logic [31:0] se;
        b  = '0;
        op = int'(w[31:26]);
        se = {{16{w[15]}}, w[15:0]};
        if (op >= 1 && op <= 15) begin
            b.rd = w[25:21]; b.rs1 = w[20:16]; b.rs2 = w[15:11]; b.shamt = w[10:6];
            b.alu_op = 5'(op); b.wb_from_alu = 1'b1; b.reg_we = 1'b1;
        end else if (op >= 16 && op <= 23) begin
            b.rd = w[25:21]; b.rs1 = w[20:16]; b.imm = se;
            b.alu_src_imm = 1'b1; b.wb_from_alu = 1'b1; b.reg_we = 1'b1;
            case (op)
                18: b.alu_op = 5'd1;
                19: b.alu_op = 5'd2;
                20: b.alu_op = 5'd3;
                21: b.alu_op = 5'd4;
                22: b.alu_op = 5'd9;
                23: b.alu_op = 5'd10;
                default: b.alu_op = 5'd0;
            endcase
        end else if (op >= 24 && op <= 27) begin
            b.alu_op = 5'd1; b.alu_src_imm = 1'b1; b.imm = se;
            if (op == 24 || op == 26) begin
                b.rd = w[25:21]; b.rs1 = w[20:16]; b.reg_we = 1'b1;
            end else begin
                b.rs1 = w[25:21]; b.rs2 = w[20:16]; b.mem_we = 1'b1;
            end
        end else if (op == 62 || op == 63) begin
            b.rs1 = w[25:21]; b.rs2 = w[20:16]; b.imm = se; b.jump = 1'b1;
            b.alu_op = (op == 62) ? 5'd16 : 5'd15;
        end else begin
            b.illegal = 1'b1;
        end
        return b;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] w,
                                 input logic ordy, input logic fl = 1'b0,
                                 input logic res = 1'b0, input logic r = 1'b0);
        in_valid  = v;
        instr     = w;
        out_ready = ordy;
        flush     = fl;
        resume    = res;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    // Advance the behavioural model on each rising edge from the applied inputs
    always @(posedge clk) begin
        logic model_ready;
        logic model_accept;
        if (rst) begin
            m_init  = 1'b1;
            m_valid = 1'b0;
            m_halt  = 1'b0;
            m_count = 0;
            m_b     = '0;
        end else if (m_init) begin
            model_ready  = !m_halt && (!m_valid || out_ready) && !flush;
            model_accept = in_valid && model_ready;
            if (flush) begin
                m_valid = 1'b0;
            end else if (model_accept && instr[31:26] != 6'd0) begin
                m_valid = 1'b1;
                m_b     = model_decode(instr);
                m_count = m_count + 1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            if (model_accept && instr[31:26] == 6'd0) m_halt = 1'b1;
            else if (m_halt && resume)                m_halt = 1'b0;
        end
    end

    // Compare both DUT instances against the model mid-cycle
    always @(negedge clk) begin
        if (m_init) begin
            logic exp_ready;
            exp_ready = !m_halt && (!m_valid || out_ready) && !flush;
            checkOutput("out_valid",    64'(out_valid),      64'(m_valid));
            checkOutput("in_ready",     64'(in_ready),       64'(exp_ready));
            checkOutput("halted",       64'(halted),         64'(m_halt));
            checkOutput("pc_enable",    64'(pc_enable),      64'(!m_halt));
            checkOutput("decode_count", 64'(decode_count),   64'((m_count > 65535) ? 65535 : m_count));
            checkOutput("small_count",  64'(s_decode_count), 64'((m_count > 3) ? 3 : m_count));
            checkOutput("small_valid",  64'(s_out_valid),    64'(m_valid));
            checkOutput("small_halted", 64'(s_halted),       64'(m_halt));
            if (m_valid) begin
                checkOutput("rd",          64'(rd),          64'(m_b.rd));
                checkOutput("rs1",         64'(rs1),         64'(m_b.rs1));
                checkOutput("rs2",         64'(rs2),         64'(m_b.rs2));
                checkOutput("shamt",       64'(shamt),       64'(m_b.shamt));
                checkOutput("imm",         64'(imm),         64'(m_b.imm));
                checkOutput("alu_op",      64'(alu_op),      64'(m_b.alu_op));
                checkOutput("alu_src_imm", 64'(alu_src_imm), 64'(m_b.alu_src_imm));
                checkOutput("wb_from_alu", 64'(wb_from_alu), 64'(m_b.wb_from_alu));
                checkOutput("reg_we",      64'(reg_we),      64'(m_b.reg_we));
                checkOutput("mem_we",      64'(mem_we),      64'(m_b.mem_we));
                checkOutput("jump",        64'(jump),        64'(m_b.jump));
                checkOutput("illegal",     64'(illegal),     64'(m_b.illegal));
                checkOutput("small_bundle",
                    64'({s_rd, s_rs1, s_rs2, s_shamt, s_imm, s_alu_op, s_alu_src_imm,
                         s_wb_from_alu, s_reg_we, s_mem_we, s_jump, s_illegal}),
                    64'(m_b));
            end
        end
    end

    // Directed sequence with hand-computed expectations
    initial begin
        logic [31:0] vecs [12];
        vecs = '{32'h4C218005, 32'h50437FFF, 32'h54000001, 32'h5BE0FFFE,
                 32'h5C000100, 32'h40000123, 32'h3FFFFFFF, 32'h68A2FFF0,
                 32'h6444000C, 32'h70000000, 32'hF7FFFFFF, 32'h4841FFFF};
        rst = 1'b1; in_valid = 1'b0; instr = '0; flush = 1'b0;
        resume = 1'b0; out_ready = 1'b1;

        // Reset state
        applyStimulus(0, 32'h0, 1, 0, 0, 1);
        applyStimulus(0, 32'h0, 1, 0, 0, 1);
        applyStimulus(0, 32'h0, 1);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_count",     64'(decode_count), 64'd0);
        checkOutput("rst_pc_enable", 64'(pc_enable), 64'd1);
        checkOutput("rst_halted",    64'(halted), 64'd0);
        checkOutput("rst_in_ready",  64'(in_ready), 64'd1);
        checkOutput("rst_fields",    64'({rd, rs1, rs2, imm, alu_op, reg_we, illegal}), 64'd0);

        // R-type
        applyStimulus(1, 32'h04642800, 1);
        checkOutput("r_valid", 64'(out_valid), 64'd1);
        checkOutput("r_regs",  64'({rd, rs1, rs2, shamt}), 64'({5'd3, 5'd4, 5'd5, 5'd0}));
        checkOutput("r_ctrl",  64'({alu_op, reg_we, alu_src_imm}), 64'({5'b00001, 1'b1, 1'b0}));
        checkOutput("r_count", 64'(decode_count), 64'd1);

        // I-type, then hold under backpressure while a store waits
        applyStimulus(1, 32'h4841FFFF, 1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 32'h6CC70010, 0);
            checkOutput("i_hold_valid", 64'(out_valid), 64'd1);
            checkOutput("i_hold_ready", 64'(in_ready), 64'd0);
            checkOutput("i_hold_regs",  64'({rd, rs1}), 64'({5'd2, 5'd1}));
            checkOutput("i_hold_imm",   64'(imm), 64'h0000_0000_FFFF_FFFF);
            checkOutput("i_hold_ctrl",  64'({alu_op, alu_src_imm}), 64'({5'b00001, 1'b1}));
        end

        // Store accepted once downstream frees up
        applyStimulus(1, 32'h6CC70010, 1);
        checkOutput("st_regs",  64'({rs1, rs2}), 64'({5'd6, 5'd7}));
        checkOutput("st_imm",   64'(imm), 64'h10);
        checkOutput("st_ctrl",  64'({mem_we, reg_we, alu_op}), 64'({1'b1, 1'b0, 5'b00001}));
        checkOutput("st_count", 64'(decode_count), 64'd3);

        // Branch equal
        applyStimulus(1, 32'hF8000000, 1);
        checkOutput("br_ctrl", 64'({jump, alu_op}), 64'({1'b1, 5'b10000}));

        // Halt: swallowed, stage frozen while fetch keeps offering
        applyStimulus(1, 32'h00000000, 1);
        checkOutput("halt_valid", 64'(out_valid), 64'd0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 32'h04642800, 1);
            checkOutput("halt_state", 64'({halted, pc_enable, in_ready}), 64'({1'b1, 1'b0, 1'b0}));
        end
        checkOutput("halt_count", 64'(decode_count), 64'd4);
        applyStimulus(0, 32'h0, 1, 0, 1);
        checkOutput("resume_state", 64'({halted, pc_enable, in_ready}), 64'({1'b0, 1'b1, 1'b1}));

        // Illegal opcode; fifth load, so the 2-bit counter is pinned at 3
        applyStimulus(1, 32'hA0000000, 1);
        checkOutput("ill_flags", 64'({illegal, reg_we, mem_we, jump, alu_src_imm, wb_from_alu}),
                    64'({1'b1, 5'b0}));
        checkOutput("ill_count",   64'(decode_count), 64'd5);
        checkOutput("small_sat",   64'(s_decode_count), 64'd3);

        // Load and a sweep of other classes checked by the model
        applyStimulus(1, 32'h60A20004, 1);
        checkOutput("ld_regs", 64'({rd, rs1}), 64'({5'd5, 5'd2}));
        checkOutput("ld_ctrl", 64'({wb_from_alu, reg_we, mem_we}), 64'({1'b0, 1'b1, 1'b0}));
        for (int k = 0; k < 12; k++) applyStimulus(1, vecs[k], 1);
        applyStimulus(1, 32'hFC22FFFC, 1);
        checkOutput("bne_alu", 64'(alu_op), 64'({59'd0, 5'b01111}));
        checkOutput("bne_imm", 64'(imm), 64'h0000_0000_FFFF_FFFC);
        applyStimulus(0, 32'h0, 1, 0, 1);

        // Flush with a bundle waiting and a same-cycle input offered
        applyStimulus(1, 32'h04642800, 1);
        applyStimulus(0, 32'h0, 0);
        in_valid = 1'b1; instr = 32'h4841FFFF; out_ready = 1'b0; flush = 1'b1;
        #1;
        checkOutput("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        checkOutput("flush_valid", 64'(out_valid), 64'd0);
        checkOutput("flush_count", 64'(decode_count), 64'd20);
        applyStimulus(0, 32'h0, 1);
        checkOutput("flush_dropped", 64'(out_valid), 64'd0);

        // Reset with a bundle in flight, then reset out of HALT
        applyStimulus(1, 32'h04642800, 0);
        applyStimulus(0, 32'h0, 0, 0, 0, 1);
        checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
        applyStimulus(1, 32'h00000000, 1);
        checkOutput("halt2", 64'(halted), 64'd1);
        applyStimulus(0, 32'h0, 1, 0, 0, 1);
        checkOutput("hrst_state", 64'({halted, pc_enable, in_ready, out_valid}),
                    64'({1'b0, 1'b1, 1'b1, 1'b0}));
        checkOutput("hrst_fields", 64'({rd, rs1, imm, alu_op, jump, illegal}), 64'd0);
        checkOutput("hrst_count",  64'(decode_count), 64'd0);
        applyStimulus(0, 32'h0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised instruction-decode pipeline stage for the single-issue CPU. It sits between instruction fetch and register-read/ALU.
- Accepts one 32-bit instruction per valid/ready handshake, decodes opcode class, register fields, sign-extended immediate and ALU op, and presents them one cycle later on a valid/ready output.
- Adds a HALT/RUN state machine (opcode 0 stops PC until resume), pipeline flush, illegal-opcode flagging and a saturating decode counter.

Parameters:
- XLEN, 32, datapath width; immediate is sign-extended from 16 bits to XLEN.
- RA_W, 5, register-address width; must be ≤5 because fields are fixed in the 32-bit encoding.
- CNT_W, 16, width of the saturating decoded-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch offers instr.
- in_ready  out  1  stage can accept.
- instr  in  32  instruction word; opcode = instr[31:26].
- flush  in  1  discard the output register contents and drop any same-cycle input.
- resume  in  1  leave HALT.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts.
- rd, rs1, rs2  out  RA_W each  register addresses.
- shamt  out  5  shift amount.
- imm  out  XLEN  sign-extended immediate.
- alu_op  out  5  ALU operation code.
- alu_src_imm  out  1  ALU operand B source: 1 = immediate.
- wb_from_alu  out  1  write-back source: 1 = ALU, 0 = memory.
- reg_we  out  1  register write enable.
- mem_we  out  1  memory write enable.
- jump  out  1  branch/jump select.
- illegal  out  1  unsupported opcode.
- pc_enable  out  1  0 while halted.
- halted  out  1  FSM is in HALT.
- decode_count  out  CNT_W  number of instructions emitted, saturating.

Behaviour:
- Reset: FSM enters RUN. out_valid=0, every bundle field=0, decode_count=0, pc_enable=1, halted=0.
- Output register: in_ready = (state==RUN) & (~out_valid | out_ready) & ~flush. An instruction is accepted when in_valid & in_ready, and its bundle is registered with 1-cycle latency. An output is consumed when out_valid & out_ready, which clears out_valid unless a new instruction is loaded in the same cycle.
- Bundle stability: the bundle holds while out_valid & ~out_ready.
- Unused fields: driven 0, never Z.
- Decode classes by opcode (op):
  - op 0: halt. The instruction is consumed and not emitted. Next state is HALT.
  - op 1–15, R-type: rd=[25:21], rs1=[20:16], rs2=[15:11], shamt=[10:6], alu_op={0,op[3:0]}. alu_src_imm=0, wb_from_alu=1, reg_we=1.
  - op 16–23, I-type: rd=[25:21], rs1=[20:16], imm=sext([15:0]). alu_src_imm=1, wb_from_alu=1, reg_we=1.
    - alu_op from op[3:0]: 2→00001, 3→00010, 4→00011, 5→00100, 6→01001, 7→01010, other values→00000.
  - op 24–27, memory: alu_op=00001, alu_src_imm=1, imm=sext([15:0]). mem_we=op[0].
    - Loads (op 24, 26): rd=[25:21], rs1=[20:16], wb_from_alu=0, reg_we=1.
    - Stores (op 25, 27): rs1=[25:21], rs2=[20:16], reg_we=0.
  - op 62, 63, branch: rs1=[25:21], rs2=[20:16], imm=sext([15:0]), jump=1, reg_we=0. alu_op is 10000 for op 62 and 01111 for op 63.
  - op 28–61: emitted with illegal=1 and all control enables 0.
- FSM states RUN and HALT:
  - RUN→HALT: when an op-0 instruction is accepted. A bundle already in the output register still drains normally.
  - In HALT: in_ready=0, pc_enable=0, halted=1.
  - HALT→RUN: on resume.
- flush:
  - In any state, the next cycle has out_valid=0.
  - A flush in the same cycle as in_valid drops the input, because in_ready=0.
  - Flush does not change the FSM state.
- Simultaneous events: flush together with an accepted op 0 is not possible, because in_ready=0 during flush. resume while in RUN has no effect.
- decode_count: increments by 1 each time a bundle is loaded (illegal included, halt excluded) and saturates at 2^CNT_W−1.
- Reset mid-operation: an in-flight bundle is discarded, out_valid=0, state is RUN.

Decomposition:
- Shared package cpu_decode_pkg holds:
  - opcode class bounds (OP_HALT=0, R_LO=1, R_HI=15, I_LO=16, I_HI=23, M_LO=24, M_HI=27, BR_EQ=62, BR_NE=63);
  - ALU op constants;
  - the FSM state enum.
- Sub-module decode_comb holds the pure combinational instr→bundle logic. decode_stage adds the pipeline register, handshake, FSM and counter.

Test Plan:
- R-type: send 0x04642800 with out_ready=1 → next cycle out_valid=1, rd=3, rs1=4, rs2=5, shamt=0, alu_op=00001, reg_we=1, alu_src_imm=0, decode_count=1.
- I-type and backpressure: send 0x4841FFFF with out_ready=0 for 3 cycles → rd=2, rs1=1, imm=0xFFFFFFFF, alu_op=00001, alu_src_imm=1. Bundle holds and in_ready=0 until out_ready=1.
- Store: send 0x6CC70010 → rs1=6, rs2=7, imm=0x10, mem_we=1, reg_we=0, alu_op=00001. Then send branch 0xF8000000 → jump=1, alu_op=10000.
- Halt: send 0x00000000 → no out_valid, halted=1, pc_enable=0, in_ready=0 held for 5 cycles. Pulse resume → in_ready=1 the next cycle.
- Illegal and saturation: send 0xA0000000 → illegal=1 with all enables 0. Run with CNT_W=2 and 5 instructions → decode_count stops at 3.
- Flush and reset: with a bundle waiting on out_ready=0, assert flush together with in_valid → out_valid=0 next cycle and the input is dropped. Assert rst during HALT → RUN, outputs zeroed.
